// File: rtl/add_req_initiator.sv
// Start/valid adder initiator: one job in flight to a fixed-latency engine,
// results queued in a small FIFO tagged with a timeout flag.
module add_req_initiator #(
  parameter int W       = 10,
  parameter int TIMEOUT = 4,
  parameter int RDEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         eng_start,
  output logic [W-1:0] eng_a,
  output logic [W-1:0] eng_b,
  input  logic         eng_valid,
  input  logic [W-1:0] eng_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_err,
  output logic         spurious
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(RDEPTH + 1);
  localparam int PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;

  localparam logic [TW-1:0] TMO   = TW'(TIMEOUT);
  localparam logic [CW-1:0] DEPTH = CW'(RDEPTH);
  localparam logic [PW-1:0] LAST  = PW'(RDEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic         err;
    logic [W-1:0] sum;
  } res_t;

  state_t        state, state_nx;
  logic [TW-1:0] wait_cnt, wait_cnt_nx;

  res_t          mem [RDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic accept, push, pop;
  res_t push_data;

  // Slot is reserved at accept, so a push never finds the FIFO full.
  assign in_ready  = (state == IDLE) && (count < DEPTH);
  assign accept    = in_valid && in_ready;
  assign eng_start = (state == ISSUE);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_sum   = out_valid ? mem[rd_ptr].sum : '0;
  assign out_err   = out_valid ? mem[rd_ptr].err : 1'b0;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    push        = 1'b0;
    push_data   = '0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx    = WAIT;
        wait_cnt_nx = TW'(1);
      end
      WAIT: begin
        // A result on the final allowed edge beats the timeout.
        if (eng_valid) begin
          push      = 1'b1;
          push_data = '{err: 1'b0, sum: eng_y};
          state_nx  = IDLE;
        end else if (wait_cnt == TMO) begin
          push      = 1'b1;
          push_data = '{err: 1'b1, sum: '0};
          state_nx  = IDLE;
        end else begin
          wait_cnt_nx = wait_cnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      eng_a    <= '0;
      eng_b    <= '0;
      spurious <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (accept) begin
        eng_a <= in_a;
        eng_b <= in_b;
      end
      if (eng_valid && state != WAIT) spurious <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_add_req_initiator.sv
// Directed bench for add_req_initiator: nominal, timeout, backpressure,
// spurious result, timeout race and async reset mid-job.
module tb_add_req_initiator;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         eng_start;
  logic [W-1:0] eng_a, eng_b;
  logic         eng_valid;
  logic [W-1:0] eng_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_err;
  logic         spurious;

  int checks = 0;
  int errors = 0;

  add_req_initiator #(.W(W), .TIMEOUT(4), .RDEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .eng_start (eng_start),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_valid (eng_valid),
    .eng_y     (eng_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_err   (out_err),
    .spurious  (spurious)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    eng_valid = 1'b0;
    eng_y     = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_spurious", 32'(spurious), 0);
    chk("rst_eng_a", 32'(eng_a), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_start", 32'(eng_start), 0);

    // Nominal job 3+5, engine answers at E2
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 10'd3;
    in_b      = 10'd5;
    #1;
    chk("nom_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("nom_issue_start", 32'(eng_start), 1);
    chk("nom_eng_a", 32'(eng_a), 3);
    chk("nom_eng_b", 32'(eng_b), 5);
    chk("nom_issue_ready", 32'(in_ready), 0);
    step();
    chk("nom_wait_start", 32'(eng_start), 0);
    chk("nom_wait_ovalid", 32'(out_valid), 0);
    eng_valid = 1'b1;
    eng_y     = 10'd8;
    step();
    eng_valid = 1'b0;
    chk("nom_out_valid", 32'(out_valid), 1);
    chk("nom_out_sum", 32'(out_sum), 8);
    chk("nom_out_err", 32'(out_err), 0);
    chk("nom_in_ready2", 32'(in_ready), 1);
    step();
    chk("nom_popped", 32'(out_valid), 0);

    // Timeout: engine silent, push at E5
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 10'd1;
    in_b      = 10'd2;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    chk("tmo_before_valid", 32'(out_valid), 0);
    chk("tmo_before_ready", 32'(in_ready), 0);
    step();
    chk("tmo_out_valid", 32'(out_valid), 1);
    chk("tmo_out_err", 32'(out_err), 1);
    chk("tmo_out_sum", 32'(out_sum), 0);
    chk("tmo_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("tmo_popped", 32'(out_valid), 0);

    // Backpressure: two results queued, FIFO full
    in_valid = 1'b1;
    in_a     = 10'h3FF;
    in_b     = 10'h001;
    step();
    in_valid = 1'b0;
    step();
    eng_valid = 1'b1;
    eng_y     = 10'h000;
    step();
    eng_valid = 1'b0;
    chk("bp_ready_one", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_a     = 10'd7;
    in_b     = 10'd9;
    step();
    in_valid = 1'b0;
    step();
    eng_valid = 1'b1;
    eng_y     = 10'd16;
    step();
    eng_valid = 1'b0;
    chk("bp_full_ready", 32'(in_ready), 0);
    chk("bp_head_valid", 32'(out_valid), 1);
    chk("bp_head_sum", 32'(out_sum), 0);
    chk("bp_head_err", 32'(out_err), 0);
    in_valid = 1'b1;
    in_a     = 10'd11;
    step();
    chk("bp_no_accept", 32'(eng_start), 0);
    chk("bp_hold_sum", 32'(out_sum), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_second_sum", 32'(out_sum), 16);
    chk("bp_second_valid", 32'(out_valid), 1);
    step();
    chk("bp_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Spurious result while idle
    eng_valid = 1'b1;
    eng_y     = 10'h123;
    step();
    eng_valid = 1'b0;
    chk("sp_flag", 32'(spurious), 1);
    chk("sp_no_push", 32'(out_valid), 0);
    step();
    chk("sp_sticky", 32'(spurious), 1);

    // Result exactly on the TIMEOUT-th edge wins
    in_valid = 1'b1;
    in_a     = 10'd4;
    in_b     = 10'd4;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    chk("race_pending", 32'(out_valid), 0);
    eng_valid = 1'b1;
    eng_y     = 10'h155;
    step();
    eng_valid = 1'b0;
    chk("race_err", 32'(out_err), 0);
    chk("race_sum", 32'(out_sum), 32'h155);

    // Push and pop on the same edge keep the count at one
    in_valid = 1'b1;
    in_a     = 10'd20;
    in_b     = 10'd30;
    step();
    in_valid = 1'b0;
    step();
    eng_valid = 1'b1;
    eng_y     = 10'h2AA;
    out_ready = 1'b1;
    step();
    eng_valid = 1'b0;
    chk("pp_valid", 32'(out_valid), 1);
    chk("pp_sum", 32'(out_sum), 32'h2AA);
    chk("pp_in_ready", 32'(in_ready), 1);
    step();
    out_ready = 1'b0;
    chk("pp_count_one", 32'(out_valid), 0);

    // Async reset mid-WAIT with a queued result
    in_valid = 1'b1;
    in_a     = 10'd1;
    in_b     = 10'd1;
    step();
    in_valid = 1'b0;
    step();
    eng_valid = 1'b1;
    eng_y     = 10'd2;
    step();
    eng_valid = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_pre_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", 32'(eng_start), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_spur", 32'(spurious), 0);
    chk("mid_rst_eng_a", 32'(eng_a), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rel_ready", 32'(in_ready), 1);
    chk("mid_rel_start", 32'(eng_start), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
